trace_capture_buffer: RTL and testbench

- Parametrised on-chip execution trace recorder for the nano_riscv core. It is the synthesizable successor to the bench's per-cycle pc/inst/debug print loop.
- Captures {pc, inst, debug} on every retired-instruction strobe into a circular buffer.
- Supports PC-match trigger with programmable post-trigger depth, and two capture modes.
- Drains oldest-first over a valid/ready readout port after capture completes.

---
 rtl/trace_capture_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: on-chip execution trace recorder for nano_riscv.
// Each retired instruction ({pc, inst, debug}) is written into a circular
// buffer. Capture can stop on a PC-match trigger after a programmable
// number of further entries. After capture, entries drain oldest-first
// over a valid/ready port.
//
// Optional feature macro: TRACE_TIMESTAMP_EN. When it is defined, each
// entry also stores a free-running cycle counter, read out on o_rd_ts.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_arm                   pulse: clear buffer, latch mode/post count, start capture
//   i_mode                  0 = wrap (overwrite oldest), 1 = stop when full
//   i_trig_en, i_trig_pc    PC-match trigger enable and value
//   i_post_cnt              entries recorded after the trigger entry
//   i_valid, i_pc, i_inst, i_debug   retire strobe and retired data
//   i_rd_ready              readout consumer ready
//   o_rd_valid, o_rd_pc, o_rd_inst, o_rd_debug [, o_rd_ts]  oldest entry
//   o_count                 entries held (0..DEPTH)
//   o_busy, o_done          capture in progress / capture finished
//   o_overflow              sticky: an entry was overwritten in wrap mode
module trace_capture_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_arm,
  input  logic            i_mode,
  input  logic            i_trig_en,
  input  logic [XLEN-1:0] i_trig_pc,
  input  logic [AW:0]     i_post_cnt,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_debug,
  input  logic            i_rd_ready,
  output logic            o_rd_valid,
  output logic [XLEN-1:0] o_rd_pc,
  output logic [XLEN-1:0] o_rd_inst,
  output logic [XLEN-1:0] o_rd_debug,
`ifdef TRACE_TIMESTAMP_EN
  output logic [XLEN-1:0] o_rd_ts,
`endif
  output logic [AW:0]     o_count,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_overflow
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned NFIELD = 4;
`else
  localparam int unsigned NFIELD = 3;
`endif
  localparam int unsigned EW = NFIELD * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     r_post_cfg;
  logic [AW:0]     r_post_ctr;
  logic            r_mode;
  logic            r_overflow;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_load_post;
  logic            w_dec_post;
  logic            w_full;
  logic            w_stop_full;
  logic            w_trig_hit;
  logic [EW-1:0]   w_wr_data;
  logic [EW-1:0]   w_rd_entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] r_ts;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ts <= '0;
    else          r_ts <= r_ts + XLEN'(1);
  end

  assign w_wr_data = {i_pc, i_inst, i_debug, r_ts};
`else
  assign w_wr_data = {i_pc, i_inst, i_debug};
`endif

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  // In stop mode, this write fills the buffer
  assign w_stop_full = r_mode && (r_count == (AW+1)'(DEPTH - 1));
  assign w_trig_hit  = i_trig_en && (i_pc == i_trig_pc);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and datapath controls; arm overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_load_post = 1'b0;
    w_dec_post  = 1'b0;
    if (i_arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (i_valid) begin
            w_wr_en = 1'b1;
            if (w_stop_full) begin
              w_state_nxt = S_DONE;
            end else if (w_trig_hit) begin
              if (r_post_cfg == '0) begin
                w_state_nxt = S_DONE;
              end else begin
                w_load_post = 1'b1;
                w_state_nxt = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (i_valid) begin
            w_wr_en    = 1'b1;
            w_dec_post = 1'b1;
            if (w_stop_full || (r_post_ctr == (AW+1)'(1))) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_rd_en = (r_count != '0) && i_rd_ready;
        default: ;
      endcase
    end
  end

  // Pointers, occupancy, post counter and configuration latches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_post_cfg <= '0;
      r_post_ctr <= '0;
      r_mode     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_arm) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_post_ctr <= '0;
      r_overflow <= 1'b0;
      r_mode     <= i_mode;
      r_post_cfg <= i_post_cnt;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        // Full in wrap mode: oldest entry is overwritten, read pointer follows
        if (w_full) begin
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + (AW+1)'(1);
        end
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count  <= r_count - (AW+1)'(1);
      end
      if (w_load_post)     r_post_ctr <= r_post_cfg;
      else if (w_dec_post) r_post_ctr <= r_post_ctr - (AW+1)'(1);
    end
  end

  // Trace storage; contents are only visible through o_rd_valid gating
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  assign w_rd_entry = r_mem[r_rd_ptr];

  // Zero-latency readout, forced to zero when nothing is offered
  assign o_rd_valid = (r_state == S_DONE) && (r_count != '0);
  assign o_rd_pc    = o_rd_valid ? w_rd_entry[EW-1 -: XLEN]        : '0;
  assign o_rd_inst  = o_rd_valid ? w_rd_entry[EW-XLEN-1 -: XLEN]   : '0;
  assign o_rd_debug = o_rd_valid ? w_rd_entry[EW-2*XLEN-1 -: XLEN] : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign o_rd_ts    = o_rd_valid ? w_rd_entry[XLEN-1:0]            : '0;
`endif

  assign o_count    = r_count;
  assign o_busy     = (r_state == S_ARMED) || (r_state == S_POST);
  assign o_done     = (r_state == S_DONE);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed testbench for trace_capture_buffer (XLEN=32, DEPTH=16).
module tb_trace_capture_buffer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW = 4;

  logic            clk;
  logic            rst_n;
  logic            arm;
  logic            mode;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic [AW:0]     post_cnt;
  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] debug;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_inst;
  logic [XLEN-1:0] rd_debug;
  logic [AW:0]     count;
  logic            busy;
  logic            done;
  logic            overflow;
`ifdef TRACE_TIMESTAMP_EN
  logic [XLEN-1:0] rd_ts;
  logic [XLEN-1:0] ts0;
  logic [XLEN-1:0] ts1;
  logic [XLEN-1:0] ts2;
`endif

  int n_run;
  int n_fail;

  trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_arm      (arm),
    .i_mode     (mode),
    .i_trig_en  (trig_en),
    .i_trig_pc  (trig_pc),
    .i_post_cnt (post_cnt),
    .i_valid    (valid),
    .i_pc       (pc),
    .i_inst     (inst),
    .i_debug    (debug),
    .i_rd_ready (rd_ready),
    .o_rd_valid (rd_valid),
    .o_rd_pc    (rd_pc),
    .o_rd_inst  (rd_inst),
    .o_rd_debug (rd_debug),
`ifdef TRACE_TIMESTAMP_EN
    .o_rd_ts    (rd_ts),
`endif
    .o_count    (count),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic m, input logic ten, input logic [31:0] tpc, input logic [AW:0] pcnt);
    arm = 1'b1; mode = m; trig_en = ten; trig_pc = tpc; post_cnt = pcnt;
    step();
    arm = 1'b0;
  endtask

  task automatic push(input logic [31:0] p);
    valid = 1'b1; pc = p; inst = p ^ 32'hA5A5_0000; debug = p + 32'd1;
    step();
    valid = 1'b0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; arm = 1'b0; mode = 1'b0; trig_en = 1'b0; trig_pc = '0;
    post_cnt = '0; valid = 1'b0; pc = '0; inst = '0; debug = '0; rd_ready = 1'b0;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_pc", rd_pc, 32'd0);
    rst_n = 1'b1;
    step();

    // Stop mode, 16 entries fill the buffer
    do_arm(1'b1, 1'b0, 32'd0, 5'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) push(32'(4 * k));
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(count), 32'd16);
    chk("t1_ovf", 32'(overflow), 32'd0);
    push(32'h0000_0040);
    chk("t1_ignored_write", 32'(count), 32'd16);
    chk("t1_first_inst", rd_inst, 32'hA5A5_0000);
    chk("t1_first_debug", rd_debug, 32'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t1_rd_valid", 32'(rd_valid), 32'd1);
      chk("t1_rd_pc", rd_pc, 32'(4 * k));
      step();
    end
    rd_ready = 1'b0;
    chk("t1_empty_valid", 32'(rd_valid), 32'd0);
    chk("t1_empty_count", 32'(count), 32'd0);
    chk("t1_empty_done", 32'(done), 32'd1);

    // Wrap mode, 21 writes; trigger on the last with post count 0
    do_arm(1'b0, 1'b1, 32'h50, 5'd0);
    for (int k = 0; k < 20; k++) push(32'(4 * k));
    chk("t2_busy_before_trig", 32'(busy), 32'd1);
    push(32'h50);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("t2_rd_pc", rd_pc, 32'h14 + 32'(4 * k));
      step();
    end
    rd_ready = 1'b0;
    chk("t2_empty_valid", 32'(rd_valid), 32'd0);

    // Wrap mode, trigger at 0x100 with 3 post entries
    do_arm(1'b0, 1'b1, 32'h100, 5'd3);
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);
    for (int p = 32'hF0; p <= 32'h120; p += 4) push(32'(p));
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Back-pressured drain: ready alternates, each entry held then consumed
    for (int k = 0; k < 16; k++) begin
      rd_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
      chk("t4_rd_valid", 32'(rd_valid), 32'd1);
      chk("t4_rd_pc", rd_pc, 32'hF0 + 32'(4 * (k / 2)));
      step();
    end
    rd_ready = 1'b0;
    chk("t4_empty_valid", 32'(rd_valid), 32'd0);
    chk("t4_empty_count", 32'(count), 32'd0);

    // Asynchronous reset in the middle of POST
    do_arm(1'b0, 1'b1, 32'h200, 5'd5);
    push(32'h1FC);
    push(32'h200);
    push(32'h204);
    chk("t5_busy_post", 32'(busy), 32'd1);
    chk("t5_count_post", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    // Valid coincident with arm is not recorded
    valid = 1'b1; pc = 32'h300;
    do_arm(1'b0, 1'b0, 32'd0, 5'd0);
    valid = 1'b0;
    chk("t5_rearm_count", 32'(count), 32'd0);
    chk("t5_rearm_busy", 32'(busy), 32'd1);
    push(32'h304);
    chk("t5_one_write", 32'(count), 32'd1);

`ifdef TRACE_TIMESTAMP_EN
    // Valids 5, 9 and 10 cycles after arm; last one triggers
    do_arm(1'b1, 1'b1, 32'h408, 5'd0);
    for (int c = 1; c <= 10; c++) begin
      valid = (c == 5 || c == 9 || c == 10);
      pc = (c == 5) ? 32'h400 : (c == 9) ? 32'h404 : 32'h408;
      step();
    end
    valid = 1'b0;
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count", 32'(count), 32'd3);
    rd_ready = 1'b1;
    ts0 = rd_ts; step();
    ts1 = rd_ts; step();
    ts2 = rd_ts; step();
    rd_ready = 1'b0;
    chk("t6_ts_diff1", ts1 - ts0, 32'd4);
    chk("t6_ts_diff2", ts2 - ts1, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
